// File: rtl/sequence_ctrl.sv
// Memory-game sequencer: grows a random 4-bit sequence, shows it, then checks player entries.
// Optional input timeout in INPUT is enabled by defining SEQ_TIMEOUT_EN.
module sequence_ctrl #(
    parameter int MAX_LEN        = 16,
    parameter int SHOW_CYCLES    = 4,
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic [3:0] rnd,
    output logic       rnd_get,
    input  logic       btn_valid,
    input  logic [3:0] btn_val,
    output logic       show_valid,
    output logic [3:0] show_val,
    output logic       input_ready,
    output logic [6:0] level,
    output logic       fail,
    output logic       win,
    output logic [2:0] state
);

    localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int TW = $clog2(SHOW_CYCLES + 1);
    localparam logic [TW-1:0] T_LAST  = TW'(SHOW_CYCLES - 1);
    localparam logic [TW-1:0] T_ONE   = TW'(1);
    localparam logic [AW-1:0] IDX_ONE = AW'(1);
    localparam logic [6:0]    LEN_MAX = 7'(MAX_LEN);

    if (MAX_LEN < 2 || MAX_LEN > 64 || SHOW_CYCLES < 1 || SHOW_CYCLES > 65535 ||
        TIMEOUT_CYCLES < 1) begin : g_bad_param
        $error("sequence_ctrl: parameter out of legal range");
    end

    typedef enum logic [2:0] {
        S_IDLE, S_ADD, S_SHOW, S_GAP, S_INPUT, S_FAIL, S_WIN
    } state_t;

    state_t        st;
    logic [AW-1:0] idx;
    logic [TW-1:0] timer;
    logic [3:0]    mem [MAX_LEN];
    logic          last_idx;

`ifdef SEQ_TIMEOUT_EN
    localparam int OW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [OW-1:0] TO_LAST = OW'(TIMEOUT_CYCLES - 1);
    localparam logic [OW-1:0] TO_ONE  = OW'(1);
    logic [OW-1:0] tcnt;
`endif

    assign last_idx    = ({{(7 - AW){1'b0}}, idx} + 7'd1) == level;
    assign rnd_get     = (st == S_ADD);
    assign show_valid  = (st == S_SHOW);
    assign show_val    = (st == S_SHOW) ? mem[idx] : 4'd0;
    assign input_ready = (st == S_INPUT);
    assign state       = st;

    // Storage has no reset: it is always rewritten by ADD before being read.
    always_ff @(posedge clock) begin
        if (!reset && st == S_ADD) mem[level[AW-1:0]] <= rnd;
    end

    // btn_valid is a one-cycle strobe with no backpressure; it is consumed only
    // while input_ready is high and dropped in every other state.
    always_ff @(posedge clock) begin
        if (reset) begin
            st    <= S_IDLE;
            level <= 7'd0;
            idx   <= '0;
            timer <= '0;
            fail  <= 1'b0;
            win   <= 1'b0;
`ifdef SEQ_TIMEOUT_EN
            tcnt  <= '0;
`endif
        end else begin
            case (st)
                S_IDLE, S_FAIL, S_WIN: begin
                    if (start) begin
                        st    <= S_ADD;
                        level <= 7'd0;
                        fail  <= 1'b0;
                        win   <= 1'b0;
                    end
                end
                S_ADD: begin
                    level <= level + 7'd1;
                    idx   <= '0;
                    timer <= '0;
                    st    <= S_SHOW;
                end
                S_SHOW: begin
                    if (timer == T_LAST) begin
                        timer <= '0;
                        st    <= S_GAP;
                    end else begin
                        timer <= timer + T_ONE;
                    end
                end
                S_GAP: begin
                    if (timer == T_LAST) begin
                        timer <= '0;
                        if (last_idx) begin
                            idx <= '0;
                            st  <= S_INPUT;
`ifdef SEQ_TIMEOUT_EN
                            tcnt <= '0;
`endif
                        end else begin
                            idx <= idx + IDX_ONE;
                            st  <= S_SHOW;
                        end
                    end else begin
                        timer <= timer + T_ONE;
                    end
                end
                S_INPUT: begin
                    if (btn_valid) begin
`ifdef SEQ_TIMEOUT_EN
                        tcnt <= '0;
`endif
                        if (btn_val == mem[idx]) begin
                            if (!last_idx) begin
                                idx <= idx + IDX_ONE;
                            end else if (level == LEN_MAX) begin
                                st  <= S_WIN;
                                win <= 1'b1;
                            end else begin
                                st <= S_ADD;
                            end
                        end else begin
                            st   <= S_FAIL;
                            fail <= 1'b1;
                        end
                    end
`ifdef SEQ_TIMEOUT_EN
                    else if (tcnt == TO_LAST) begin
                        st   <= S_FAIL;
                        fail <= 1'b1;
                    end else begin
                        tcnt <= tcnt + TO_ONE;
                    end
`endif
                end
                default: st <= S_IDLE;
            endcase
        end
    end

endmodule
